play_receiver: RTL and testbench
================================

# play_receiver

Serial-input front end for the play path: an 8N1 UART receiver followed by a framing FSM that collects a fixed-length ASCII-digit play terminated by line feed. The play is converted to packed BCD and handed to the game datapath with a one-cycle valid strobe. This is the host-to-board direction of the link whose board-to-host side is driven by the play analyser's character transmitter.

## Interface
- `CLKS_PER_BIT`, 434, clock cycles per bit (50 MHz / 115200); must be ≥ 4
- `NCHARS`, 4, digits per play
- `TIMEOUT_CLKS`, 10*434*4, inter-character timeout; only used with `PLAY_RX_TIMEOUT_EN`
- `clock`  in  1  system clock, all logic rising-edge
- `reset`  in  1  asynchronous, active-low; clears all state
- `rx`  in  1  serial line, idle high, asynchronous to `clock`
- `habilita`  in  1  parser enable; UART runs regardless
- `jogada`  out  4*NCHARS  last accepted play, first digit in MS nibble
- `jogada_valida`  out  1  one-cycle pulse when `jogada` updates
- `erro`  out  1  one-cycle pulse on any rejected byte/frame
- `recebendo`  out  1  high while a partial play is held (char count > 0)
- `dado_rx`  out  8  last received byte (debug)
- `pronto_rx`  out  1  one-cycle pulse per received byte

## Operation
- `rx` passes a 2-flop synchronizer (reset value 1); all decisions use the synchronized signal.
- UART FSM: `IDLE` → `START` on synchronized low; `START` waits CLKS_PER_BIT/2 (integer division); if line high, glitch, return to `IDLE`, no byte; else → `DATA`.
- `DATA`: 8 samples, one every CLKS_PER_BIT, LSB first; → `STOP`.
- `STOP`: sample after CLKS_PER_BIT; line high → byte good, `pronto_rx` pulse, `dado_rx` loaded; line low → framing error, byte discarded, `erro` pulse, parser cleared. Either way → `IDLE` in the same cycle, ready for the next start edge immediately.
- Parser, on each good byte while `habilita`=1, with count `n`:
  - `n` < NCHARS and byte in 0x30..0x39 → store nibble (byte−0x30) at slot `n`, `n`++.
  - `n` = NCHARS and byte = 0x0A → copy buffer to `jogada`, pulse `jogada_valida`, `n`=0.
  - `n` = 0 and byte = 0x0A → ignored (empty line).
  - byte = 0x0D → ignored at any `n` (CRLF tolerated).
  - anything else (non-digit, (NCHARS+1)th digit, early 0x0A) → `erro` pulse, `n`=0, buffer discarded, `jogada` unchanged.
- `habilita`=0: bytes ignored by the parser, `n` forced to 0, no `erro`; `pronto_rx`/`dado_rx` still update.
- Reset values: `jogada`=0, `dado_rx`=0, all pulses 0, `recebendo`=0, UART in `IDLE`, `n`=0.
- Reset mid-frame aborts the byte; the remainder of that frame is decoded as whatever the line shows after release (the bench does not rely on it).

## Timing
- Stop-bit sample occurs at cycle T0 + CLKS_PER_BIT/2 + 9*CLKS_PER_BIT, where T0 is the first cycle synchronized `rx` is low (2–3 clocks after the pin edge).
- `pronto_rx`, `dado_rx` update: cycle after the stop sample.
- `jogada`, `jogada_valida`, `erro`, `recebendo`: one cycle after `pronto_rx` (registered parser).
- A framing-error `erro` occurs in the same cycle `pronto_rx` would have.
- `erro` and `jogada_valida` are never high together.
- Back-to-back bytes (stop bit directly followed by start) are received without loss.

## Configuration
- `PLAY_RX_TIMEOUT_EN` defined: a counter restarts on every good byte while `n`>0; after TIMEOUT_CLKS cycles with no byte, `erro` pulses once, `n`=0. The counter is idle while `n`=0.
- Not defined: no counter is synthesized, and a partial play is held indefinitely.

## Test plan
- CLKS_PER_BIT=8, NCHARS=4: send "1234\n" → `jogada`=16'h1234, one `jogada_valida` pulse one cycle after the LF `pronto_rx`, no `erro`.
- Send "12a" then "5678\r\n" → `erro` pulse on 'a', `jogada` unchanged; then `jogada`=16'h5678, CR ignored.
- Send "12\n" then "12345" → `erro` on the LF, then `erro` on '5'; `jogada` keeps its prior value; `recebendo` falls with each error.
- Drive a byte with stop bit 0, and separately a 3-cycle low glitch → `erro` for the first, no `pronto_rx` for the glitch; then "0099\n" → `jogada`=16'h0099.
- With `PLAY_RX_TIMEOUT_EN`, TIMEOUT_CLKS=200: send "12", then idle 250 cycles → single `erro` near cycle 200; then "3456\n" → 16'h3456. Without the macro, the same stimulus gives no `erro`, and "34\n" then yields 16'h1234.
- Pull `reset` low mid-byte and while `n`=2 → all outputs return to their reset values; "4321\n" after release → 16'h4321.

Source files
------------

// File: rtl/play_receiver_if.sv
// Serial line plus parsed-play outputs of play_receiver; the DUT takes the slave side.
// Latency: none (wires only). Backpressure: none; every strobe is a single-cycle pulse.
// The driver of rx/habilita takes the master side.
interface play_receiver_if #(
    parameter int NCHARS = 4
);
    logic                  rx;
    logic                  habilita;
    logic [4*NCHARS-1:0]   jogada;
    logic                  jogada_valida;
    logic                  erro;
    logic                  recebendo;
    logic [7:0]            dado_rx;
    logic                  pronto_rx;

    modport master (
        output rx, habilita,
        input  jogada, jogada_valida, erro, recebendo, dado_rx, pronto_rx
    );

    modport slave (
        input  rx, habilita,
        output jogada, jogada_valida, erro, recebendo, dado_rx, pronto_rx
    );
endinterface

// File: rtl/play_receiver.sv
// 8N1 UART receiver plus a framing parser that turns NCHARS ASCII digits and an LF into packed BCD.
// Latency: pronto_rx one cycle after the stop sample; jogada/jogada_valida one cycle after that.
// Backpressure: none. Optional PLAY_RX_TIMEOUT_EN drops a partial play after TIMEOUT_CLKS idle cycles.
module play_receiver #(
    parameter int CLKS_PER_BIT = 434,
    parameter int NCHARS       = 4,
    parameter int TIMEOUT_CLKS = 10*434*4
) (
    input  logic           clock,
    input  logic           reset,
    play_receiver_if.slave bus
);
    localparam int HALF = CLKS_PER_BIT / 2;
    localparam int CW   = $clog2(CLKS_PER_BIT);
    localparam int NW   = $clog2(NCHARS + 1);

    typedef enum logic [1:0] {S_IDLE, S_START, S_DATA, S_STOP} uart_state_t;

    uart_state_t         state;
    logic                rx_meta, rx_sync;
    logic [CW-1:0]       clk_cnt;
    logic [2:0]          bit_idx;
    logic [7:0]          shift_q;
    logic                frame_err;
    logic                parse_err;
    logic [NW-1:0]       n_q;
    logic [4*NCHARS-1:0] buf_q;
    logic [4*NCHARS-1:0] buf_shift;
    logic                is_digit;
    logic                to_hit;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= bus.rx;
            rx_sync <= rx_meta;
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            clk_cnt       <= '0;
            bit_idx       <= '0;
            shift_q       <= '0;
            bus.dado_rx   <= '0;
            bus.pronto_rx <= 1'b0;
            frame_err     <= 1'b0;
        end else begin
            bus.pronto_rx <= 1'b0;
            frame_err     <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (!rx_sync) begin
                        state   <= S_START;
                        clk_cnt <= '0;
                    end
                end
                S_START: begin
                    if (clk_cnt == CW'(HALF - 1)) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        // Line back high at mid-start means a glitch, not a frame.
                        state   <= rx_sync ? S_IDLE : S_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_DATA: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        shift_q <= {rx_sync, shift_q[7:1]};
                        bit_idx <= bit_idx + 1'b1;
                        if (bit_idx == 3'd7) state <= S_STOP;
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                S_STOP: begin
                    if (clk_cnt == CW'(CLKS_PER_BIT - 1)) begin
                        clk_cnt <= '0;
                        state   <= S_IDLE;
                        if (rx_sync) begin
                            bus.pronto_rx <= 1'b1;
                            bus.dado_rx   <= shift_q;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // Digits shift in from the right, so after NCHARS of them the first sits in the MS nibble.
    always_comb begin
        buf_shift      = buf_q << 4;
        buf_shift[3:0] = bus.dado_rx[3:0];
    end

    assign is_digit = (bus.dado_rx >= 8'h30) && (bus.dado_rx <= 8'h39);

`ifdef PLAY_RX_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CLKS + 1);
    logic [TW-1:0] to_cnt;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            to_cnt <= '0;
        end else if (n_q == '0 || bus.pronto_rx) begin
            to_cnt <= '0;
        end else if (!to_hit) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    assign to_hit = (to_cnt == TW'(TIMEOUT_CLKS - 1));
`else
    assign to_hit = 1'b0;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            n_q               <= '0;
            buf_q             <= '0;
            bus.jogada        <= '0;
            bus.jogada_valida <= 1'b0;
            parse_err         <= 1'b0;
        end else begin
            bus.jogada_valida <= 1'b0;
            parse_err         <= 1'b0;
            if (!bus.habilita || frame_err) begin
                n_q <= '0;
            end else if (bus.pronto_rx) begin
                if (bus.dado_rx == 8'h0D) begin
                    n_q <= n_q;
                end else if (is_digit && n_q < NW'(NCHARS)) begin
                    buf_q <= buf_shift;
                    n_q   <= n_q + 1'b1;
                end else if (bus.dado_rx == 8'h0A && n_q == NW'(NCHARS)) begin
                    bus.jogada        <= buf_q;
                    bus.jogada_valida <= 1'b1;
                    n_q               <= '0;
                end else if (bus.dado_rx == 8'h0A && n_q == '0) begin
                    n_q <= n_q;
                end else begin
                    parse_err <= 1'b1;
                    n_q       <= '0;
                end
            end else if (to_hit && n_q != '0) begin
                parse_err <= 1'b1;
                n_q       <= '0;
            end
        end
    end

    // Framing errors surface in the pronto_rx slot, parser errors one cycle later; they never overlap.
    assign bus.erro      = frame_err | parse_err;
    assign bus.recebendo = (n_q != '0);
endmodule

// File: tb/tb_play_receiver.sv
// Randomised serial stimulus for play_receiver checked against a queue-based play model.
module tb_play_receiver;
    localparam int C   = 8;
    localparam int NCH = 4;
    localparam int TO  = 200;

    logic clock = 1'b0;
    logic reset = 1'b0;
    always #5 clock = ~clock;

    play_receiver_if #(.NCHARS(NCH)) bus();

    play_receiver #(.CLKS_PER_BIT(C), .NCHARS(NCH), .TIMEOUT_CLKS(TO)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;

    logic [7:0]       exp_q[$];
    int               digs[$];
    logic [4*NCH-1:0] exp_jog = '0;
    logic             exp_jv, exp_er;
    int               exp_err_total = 0, exp_jv_total = 0;
    int               erro_cnt = 0, jv_cnt = 0, rx_cnt = 0;
    bit               pend = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [4*NCH-1:0] jog_of();
        logic [4*NCH-1:0] v = '0;
        foreach (digs[i]) v = (v << 4) | (4*NCH)'(digs[i]);
        return v;
    endfunction

    task automatic apply_byte(input logic [7:0] b);
        exp_jv = 1'b0;
        exp_er = 1'b0;
        if (bus.habilita) begin
            if (b == 8'h0D) begin
                exp_jv = 1'b0;
            end else if (b >= "0" && b <= "9" && digs.size() < NCH) begin
                digs.push_back(int'(b) - 48);
            end else if (b == 8'h0A && digs.size() == NCH) begin
                exp_jog = jog_of();
                exp_jv  = 1'b1;
                exp_jv_total++;
                digs.delete();
            end else if (b == 8'h0A && digs.size() == 0) begin
                exp_jv = 1'b0;
            end else begin
                exp_er = 1'b1;
                exp_err_total++;
                digs.delete();
            end
        end
    endtask

    always @(negedge clock) begin
        logic [7:0] b;
        if (!reset) begin
            pend = 0;
        end else begin
            if (bus.erro) erro_cnt++;
            if (bus.jogada_valida) jv_cnt++;
            if (bus.erro || bus.jogada_valida) check("excl", bus.erro & bus.jogada_valida, 1'b0);
            if (pend) begin
                pend = 0;
                check("jv", bus.jogada_valida, exp_jv);
                check("erro", bus.erro, exp_er);
                check("jogada", bus.jogada, exp_jog);
                check("recebendo", bus.recebendo, digs.size() != 0);
            end
            if (bus.pronto_rx) begin
                rx_cnt++;
                check("rx_expected", exp_q.size() != 0, 1'b1);
                if (exp_q.size() != 0) begin
                    b = exp_q.pop_front();
                    check("dado_rx", bus.dado_rx, b);
                    apply_byte(b);
                    pend = 1;
                end
            end
        end
    end

    task automatic idle(input int n);
        repeat (n) @(negedge clock);
    endtask

    // Starts and ends on a falling edge; tchk checks the pronto/erro slot one cycle before the stop bit ends.
    task automatic send_raw(input logic [7:0] b, input logic stop, input bit tchk);
        bus.rx = 1'b0;
        repeat (C) @(negedge clock);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            repeat (C) @(negedge clock);
        end
        bus.rx = stop;
        repeat (C - 1) @(negedge clock);
        if (tchk) begin
            if (stop) check("pronto_slot", bus.pronto_rx, 1'b1);
            else      check("frame_slot", bus.erro, 1'b1);
        end
        @(negedge clock);
        bus.rx = 1'b1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        exp_q.push_back(b);
        send_raw(b, 1'b1, 1'b1);
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) send_byte(s[i]);
    endtask

    task automatic set_hab(input logic v);
        bus.habilita = v;
        if (!v) digs.delete();
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_jog"}, bus.jogada, 0);
        check({tag, "_dado"}, bus.dado_rx, 0);
        check({tag, "_pulses"}, {bus.jogada_valida, bus.erro, bus.pronto_rx}, 0);
        check({tag, "_rcv"}, bus.recebendo, 0);
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: got timeout expected finish");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        int rxb;
        bus.rx       = 1'b1;
        bus.habilita = 1'b1;
        idle(3);
        check_reset_vals("rst0");
        reset = 1'b1;
        idle(4);

        send_str("1234\n");
        idle(3);
        check("t1_jog", bus.jogada, 16'h1234);
        check("t1_jv", jv_cnt, 1);
        check("t1_err", erro_cnt, 0);

        send_str("12a");
        idle(3);
        check("t2_err", erro_cnt, 1);
        check("t2_jog", bus.jogada, 16'h1234);
        send_str("5678\r\n");
        idle(3);
        check("t2_jog2", bus.jogada, 16'h5678);

        send_str("12\n");
        idle(3);
        check("t3_rcv", bus.recebendo, 1'b0);
        send_str("12345");
        idle(3);
        check("t3_err", erro_cnt, 3);
        check("t3_jog", bus.jogada, 16'h5678);

        send_str("12");
        idle(3);
        send_raw(8'h35, 1'b0, 1'b1);
        exp_err_total++;
        digs.delete();
        idle(20);
        check("frm_rcv", bus.recebendo, 1'b0);
        check("frm_err", erro_cnt, exp_err_total);
        rxb = rx_cnt;
        bus.rx = 1'b0;
        idle(3);
        bus.rx = 1'b1;
        idle(30);
        check("glitch_rx", rx_cnt, rxb);
        send_str("0099\n");
        idle(3);
        check("t4_jog", bus.jogada, 16'h0099);

        send_str("12");
        idle(250);
`ifdef PLAY_RX_TIMEOUT_EN
        exp_err_total++;
        digs.delete();
        check("to_err", erro_cnt, exp_err_total);
        check("to_rcv", bus.recebendo, 1'b0);
        send_str("3456\n");
        idle(3);
        check("to_jog", bus.jogada, 16'h3456);
`else
        check("to_err", erro_cnt, exp_err_total);
        check("to_rcv", bus.recebendo, 1'b1);
        send_str("34\n");
        idle(3);
        check("to_jog", bus.jogada, 16'h1234);
`endif

        send_str("12");
        idle(2);
        fork
            send_raw(8'h37, 1'b1, 1'b0);
            begin
                idle(30);
                reset = 1'b0;
                idle(2);
                check_reset_vals("rst1");
            end
        join
        exp_q.delete();
        digs.delete();
        exp_jog = '0;
        idle(5);
        check_reset_vals("rst2");
        reset = 1'b1;
        idle(5);
        send_str("4321\n");
        idle(3);
        check("t6_jog", bus.jogada, 16'h4321);

        erro_cnt = 0;
        jv_cnt   = 0;
        exp_err_total = 0;
        exp_jv_total  = 0;
        for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 1) == 0) begin
                for (int d = 0; d < NCH; d++) send_byte(8'h30 + 8'($urandom_range(0, 9)));
                if ($urandom_range(0, 2) == 0) send_byte(8'h0D);
                send_byte(8'h0A);
            end else begin
                int r = $urandom_range(0, 15);
                if (r < 10)       send_byte(8'h30 + 8'(r));
                else if (r < 12)  send_byte(8'h0A);
                else if (r == 12) send_byte(8'h0D);
                else if (r == 13) send_byte("a");
                else if (r == 14) send_byte(8'h2F);
                else              send_byte(8'h3A);
            end
            if ($urandom_range(0, 3) != 0) idle($urandom_range(1, 20));
            if ($urandom_range(0, 15) == 0) begin
                idle(2);
                set_hab(~bus.habilita);
            end else if (!bus.habilita && $urandom_range(0, 3) == 0) begin
                idle(2);
                set_hab(1'b1);
            end
        end
        idle(20);
        check("q_empty", exp_q.size(), 0);
        check("err_total", erro_cnt, exp_err_total);
        check("jv_total", jv_cnt, exp_jv_total);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
